// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserialiser slice.
package sipo_pkg;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 8;

  // Bit-counter width for a given word length.
  function automatic int unsigned sipo_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Word handshake between the deserialiser (master) and its consumer (slave).
interface sipo_deser_if
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             word_ready;

  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);

endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; flags the bit that completes a frame.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned CW       = sipo_cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             si,
  input  logic             si_en,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    bit_cnt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             frame_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // q_nxt is the value q takes on an accepted bit, so it is also the completed word.
  always_comb begin
    q_nxt = q;
    if (MSB_FIRST) q_nxt = {q[WIDTH-2:0], si};
    else           q_nxt = {si, q[WIDTH-1:1]};
  end

  assign frame_done = si_en && !clr && (bit_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      q       <= '0;
      bit_cnt <= '0;
    end else if (si_en) begin
      q       <= q_nxt;
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with a one-word holding register and overrun flag.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned CW       = sipo_cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             si,
  input  logic             si_en,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  sipo_deser_if.master     bus
);

  logic [WIDTH-1:0] q_nxt;
  logic             frame_done;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .si         (si),
    .si_en      (si_en),
    .q          (q),
    .bit_cnt    (bit_cnt),
    .q_nxt      (q_nxt),
    .frame_done (frame_done)
  );

  // A completing frame may replace a word being consumed on the same edge;
  // otherwise an unconsumed word is kept and the new one is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.word       <= '0;
      bus.word_valid <= 1'b0;
      overrun        <= 1'b0;
    end else if (clr) begin
      bus.word_valid <= 1'b0;
      overrun        <= 1'b0;
    end else if (frame_done) begin
      if (!bus.word_valid || bus.word_ready) begin
        bus.word       <= q_nxt;
        bus.word_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (bus.word_valid && bus.word_ready) begin
      bus.word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench: LSB-first and MSB-first instances driven by the same serial stream.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       si = 1'b0;
  logic       si_en = 1'b0;
  logic [7:0] q0, q1;
  logic [2:0] cnt0, cnt1;
  logic       ovr0, ovr1;
  int         total = 0;
  int         bad = 0;

  sipo_deser_if #(.WIDTH(8)) bus0 ();
  sipo_deser_if #(.WIDTH(8)) bus1 ();

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .si(si), .si_en(si_en),
    .q(q0), .bit_cnt(cnt0), .overrun(ovr0), .bus(bus0)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .si(si), .si_en(si_en),
    .q(q1), .bit_cnt(cnt1), .overrun(ovr1), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic set_ready(input logic r);
    bus0.word_ready = r;
    bus1.word_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    si    = b;
    si_en = 1'b1;
    tick();
  endtask

  // Sends v[0] first.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic test_reset();
    #3;
    total++; if (q0 !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q0); end
    total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
    total++; if (bus0.word !== 8'h00) begin bad++; $display("FAIL reset_word got=%h exp=00", bus0.word); end
    total++; if (bus0.word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus0.word_valid); end
    total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", ovr0); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_ready(1'b1);
    send_bits(8'h4D, 7);
    total++; if (cnt0 !== 3'd7) begin bad++; $display("FAIL basic_cnt7 got=%0d exp=7", cnt0); end
    total++; if (bus0.word_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", bus0.word_valid); end
    send_bit(1'b0);
    si_en = 1'b0;
    total++; if (bus0.word !== 8'h4D) begin bad++; $display("FAIL basic_lsb_word got=%h exp=4d", bus0.word); end
    total++; if (bus1.word !== 8'hB2) begin bad++; $display("FAIL basic_msb_word got=%h exp=b2", bus1.word); end
    total++; if (bus0.word_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", bus0.word_valid); end
    total++; if (bus1.word_valid !== 1'b1) begin bad++; $display("FAIL basic_msb_valid got=%b exp=1", bus1.word_valid); end
    total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL basic_cnt_wrap got=%0d exp=0", cnt0); end
    total++; if (q1 !== 8'hB2) begin bad++; $display("FAIL basic_msb_q got=%h exp=b2", q1); end
    tick();
    total++; if (bus0.word_valid !== 1'b0) begin bad++; $display("FAIL basic_consume got=%b exp=0", bus0.word_valid); end
    total++; if (bus0.word !== 8'h4D) begin bad++; $display("FAIL basic_word_hold got=%h exp=4d", bus0.word); end
  endtask

  task automatic test_back_to_back_overrun();
    set_ready(1'b0);
    send_bits(8'hA5, 8);
    total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL b2b_ovr_first got=%b exp=0", ovr0); end
    send_bits(8'h3C, 8);
    si_en = 1'b0;
    total++; if (bus0.word !== 8'hA5) begin bad++; $display("FAIL b2b_word_kept got=%h exp=a5", bus0.word); end
    total++; if (bus1.word !== 8'hA5) begin bad++; $display("FAIL b2b_msb_word_kept got=%h exp=a5", bus1.word); end
    total++; if (ovr0 !== 1'b1) begin bad++; $display("FAIL b2b_ovr got=%b exp=1", ovr0); end
    total++; if (ovr1 !== 1'b1) begin bad++; $display("FAIL b2b_msb_ovr got=%b exp=1", ovr1); end
    total++; if (q0 !== 8'h3C) begin bad++; $display("FAIL b2b_q got=%h exp=3c", q0); end
    set_ready(1'b1);
    tick();
    total++; if (ovr0 !== 1'b1) begin bad++; $display("FAIL b2b_ovr_sticky got=%b exp=1", ovr0); end
    set_ready(1'b0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL clr_ovr got=%b exp=0", ovr0); end
    total++; if (bus0.word_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", bus0.word_valid); end
    total++; if (bus0.word !== 8'hA5) begin bad++; $display("FAIL clr_word_hold got=%h exp=a5", bus0.word); end
  endtask

  task automatic test_clr_midframe();
    set_ready(1'b1);
    send_bits(8'hFF, 3);
    total++; if (cnt0 !== 3'd3) begin bad++; $display("FAIL mid_cnt got=%0d exp=3", cnt0); end
    si = 1'b1;
    si_en = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL mid_clr_cnt got=%0d exp=0", cnt0); end
    total++; if (q0 !== 8'h00) begin bad++; $display("FAIL mid_clr_q got=%h exp=00", q0); end
    send_bits(8'h96, 8);
    si_en = 1'b0;
    total++; if (bus0.word !== 8'h96) begin bad++; $display("FAIL mid_word got=%h exp=96", bus0.word); end
    total++; if (bus1.word !== 8'h69) begin bad++; $display("FAIL mid_msb_word got=%h exp=69", bus1.word); end
  endtask

  task automatic test_complete_with_ready();
    set_ready(1'b1);
    tick();
    total++; if (bus0.word_valid !== 1'b0) begin bad++; $display("FAIL cwr_drain got=%b exp=0", bus0.word_valid); end
    set_ready(1'b0);
    send_bits(8'h5A, 8);
    send_bits(8'h1E, 7);
    total++; if (bus0.word !== 8'h5A) begin bad++; $display("FAIL cwr_word_stable got=%h exp=5a", bus0.word); end
    set_ready(1'b1);
    send_bit(1'b0);
    si_en = 1'b0;
    total++; if (bus0.word !== 8'h1E) begin bad++; $display("FAIL cwr_word got=%h exp=1e", bus0.word); end
    total++; if (bus1.word !== 8'h78) begin bad++; $display("FAIL cwr_msb_word got=%h exp=78", bus1.word); end
    total++; if (bus0.word_valid !== 1'b1) begin bad++; $display("FAIL cwr_valid got=%b exp=1", bus0.word_valid); end
    total++; if (ovr0 !== 1'b0) begin bad++; $display("FAIL cwr_ovr got=%b exp=0", ovr0); end
    tick();
    total++; if (bus0.word_valid !== 1'b0) begin bad++; $display("FAIL cwr_consume got=%b exp=0", bus0.word_valid); end
  endtask

  task automatic test_gaps();
    logic [7:0] v;
    v = 8'h4D;
    set_ready(1'b1);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      si_en = 1'b0;
      si = ~v[i];
      tick();
      tick();
      if (i == 2) begin
        total++; if (cnt0 !== 3'd3) begin bad++; $display("FAIL gap_cnt_hold got=%0d exp=3", cnt0); end
      end
    end
    total++; if (bus0.word !== 8'h4D) begin bad++; $display("FAIL gap_word got=%h exp=4d", bus0.word); end
    total++; if (bus1.word !== 8'hB2) begin bad++; $display("FAIL gap_msb_word got=%h exp=b2", bus1.word); end
  endtask

  task automatic test_reset_midframe();
    send_bits(8'hFF, 4);
    si_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (q0 !== 8'h00) begin bad++; $display("FAIL rst_q got=%h exp=00", q0); end
    total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt0); end
    total++; if (bus0.word !== 8'h00) begin bad++; $display("FAIL rst_word got=%h exp=00", bus0.word); end
    total++; if (bus1.word !== 8'h00) begin bad++; $display("FAIL rst_msb_word got=%h exp=00", bus1.word); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (bus0.word_valid !== 1'b0) begin bad++; $display("FAIL rst_no_pulse got=%b exp=0", bus0.word_valid); end
    send_bits(8'hC6, 7);
    total++; if (bus0.word_valid !== 1'b0) begin bad++; $display("FAIL rst_early_valid got=%b exp=0", bus0.word_valid); end
    send_bit(1'b1);
    si_en = 1'b0;
    total++; if (bus0.word !== 8'hC6) begin bad++; $display("FAIL rst_word_new got=%h exp=c6", bus0.word); end
    total++; if (bus1.word !== 8'h63) begin bad++; $display("FAIL rst_msb_word_new got=%h exp=63", bus1.word); end
    total++; if (bus0.word_valid !== 1'b1) begin bad++; $display("FAIL rst_valid got=%b exp=1", bus0.word_valid); end
  endtask

  initial begin
    set_ready(1'b0);
    test_reset();
    test_basic();
    test_back_to_back_overrun();
    test_clr_midframe();
    test_complete_with_ready();
    test_gaps();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 0; 0 = first received bit ends in word[0], 1 = first received bit ends in word[WIDTH-1].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous clear of frame, holding register and flags.
REQ-006 si  input  1  serial data bit.
REQ-007 si_en  input  1  qualifies si; one bit is accepted per cycle with si_en=1.
REQ-008 q  output  WIDTH  live shift-register contents.
REQ-009 bit_cnt  output  CW  bits accepted in the current frame, 0..WIDTH-1, where CW = $clog2(WIDTH).
REQ-010 word  output  WIDTH  last completed word, held while word_valid=1.
REQ-011 word_valid  output  1  word holds an unconsumed completed word.
REQ-012 word_ready  input  1  consumer accepts word when word_valid=1 and word_ready=1.
REQ-013 overrun  output  1  sticky: a completed word was dropped.

Function
REQ-014 With si_en=1, MSB_FIRST=0: q[WIDTH-1] <= si, q[i] <= q[i+1] for i < WIDTH-1.
REQ-015 With si_en=1, MSB_FIRST=1: q[0] <= si, q[i] <= q[i-1] for i > 0.
REQ-016 With si_en=0 and clr=0, q and bit_cnt SHALL hold.
REQ-017 bit_cnt SHALL increment by 1 per accepted bit and wrap from WIDTH-1 to 0.
REQ-018 Frame completes on the cycle with si_en=1 and bit_cnt=WIDTH-1; the completed word is the value q takes on that edge, including the current si.
REQ-019 On completion with word_valid=0, or with word_valid=1 and word_ready=1: word <= completed word and word_valid <= 1 on the same edge; latency is 1 cycle from the last bit.
REQ-020 On completion with word_valid=1 and word_ready=0: the new word SHALL be dropped, word and word_valid SHALL hold, and overrun <= 1.
REQ-021 Without completion, word_valid=1 and word_ready=1 SHALL clear word_valid on the next edge; word holds its value.
REQ-022 word SHALL NOT change while word_valid=1 and word_ready=0.
REQ-023 overrun SHALL remain 1 until clr or reset.
REQ-024 clr=1 SHALL take priority over si_en and word_ready: q, bit_cnt, word_valid and overrun <= 0, and word holds its value.
REQ-025 A clr mid-frame SHALL discard the partial frame; the next accepted bit starts a new frame at bit_cnt=0.
REQ-026 Back-to-back frames with si_en=1 every cycle SHALL complete every WIDTH cycles with no bit lost.

Reset
REQ-027 rst_n=0 SHALL asynchronously set q=0, bit_cnt=0, word=0, word_valid=0 and overrun=0.
REQ-028 Deassertion of rst_n SHALL take effect on clock edges only; the first bit is accepted on the first rising edge with rst_n=1 and si_en=1.
REQ-029 Reset mid-frame or mid-handshake SHALL discard all state; no word_valid pulse SHALL follow reset.

Structure
REQ-030 Shared package sipo_pkg SHALL hold SIPO_DEFAULT_WIDTH=8 and the counter-width helper (clog2 of WIDTH).
REQ-031 Shift path and bit counter SHALL form one sub-module, sipo_shift_core (q, bit_cnt, frame-complete strobe).
REQ-032 sipo_deser SHALL wrap sipo_shift_core and own the holding register, handshake and overrun.

Verification (WIDTH=8 unless stated)
REQ-033 MSB_FIRST=0, serial 1,0,1,1,0,0,1,0 with si_en=1 each cycle, word_ready=1 -> word=8'h4D and word_valid=1 one cycle after the 8th bit.
REQ-034 MSB_FIRST=1, same bit stream -> word=8'hB2.
REQ-035 Two back-to-back frames 8'hA5 then 8'h3C, word_ready=0 throughout -> word stays 8'hA5, overrun=1 after the 16th bit; clr -> overrun=0, word_valid=0.
REQ-036 Frame completes in the same cycle word_valid=1 and word_ready=1 -> word updates to the new value, word_valid stays 1, overrun stays 0.
REQ-037 si_en gaps (1 bit every 3 cycles) -> same word as the gap-free run; bit_cnt holds during gaps.
REQ-038 rst_n pulsed low after 4 bits, then a full 8-bit frame -> all outputs 0 during reset; the next word contains only the 8 post-reset bits.
